trace_packet_decoder: RTL and testbench
=======================================

// Module: trace_packet_decoder
// PURPOSE
//  Receive end of the RAM-tracer packet stream: consumes {packet_type, packet_payload} words as produced by the tracing state machine.
//  Reconstructs absolute bus events: burst addresses, per-word read/write data, a 32-bit absolute cycle time.
//  Used in the hardware loopback/replay path and as the golden decoder for tracer self-test.
//  Timestamp packets are absorbed and emit no event.
// PARAMETERS
//  TIME_W    32   width of absolute time accumulator (wraps mod 2^TIME_W)
//  ADDR_W    23   RAM word-address width
// PORTS
//  mclk        in   1       system clock; all logic on posedge
//  reset       in   1       synchronous, active-high reset
//  in_valid    in   1       input packet valid
//  in_ready    out  1       input packet accepted when in_valid && in_ready
//  in_type     in   2       00=ADDR 01=READ 10=WRITE 11=TIMESTAMP
//  in_payload  in   23      ADDR: address; READ/WRITE: {ts5[22:18], ublb[17:16], data[15:0]}; TIMESTAMP: cycle delta
//  ev_valid    out  1       decoded event valid
//  ev_ready    in   1       event consumed when ev_valid && ev_ready
//  ev_type     out  2       00=ADDR 01=READ 10=WRITE (11 never emitted)
//  ev_addr     out  ADDR_W  word address of event
//  ev_data     out  16      data word (0 for ADDR)
//  ev_ublb     out  2       raw ublb bits as sampled (0 for ADDR)
//  ev_time     out  TIME_W  absolute cycle time of event
//  err_orphan  out  1       sticky: data packet seen with no burst open
// BEHAVIOUR
//  - One clock domain, sync active-high reset. All outputs reset to 0; time_acc=0, state=NO_BURST.
//  - Single output register: in_ready = !ev_valid || ev_ready (combinational). Full throughput 1 pkt/clk.
//  - ev_* fields held stable while ev_valid && !ev_ready. ev_valid clears on consume unless a new event loads in same cycle.
//  - Latency: accepted packet -> ev_valid asserted next clock.
//  - States: NO_BURST, IN_BURST.
//  - ADDR (any state): cur_addr<=payload; ->IN_BURST; emit ADDR event, ev_time=time_acc (no time advance).
//  - READ/WRITE in IN_BURST: t=time_acc+ts5; time_acc<=t; emit event ev_addr=cur_addr, ev_time=t; cur_addr<=cur_addr+1 mod 2^ADDR_W (0x7FFFFF -> 0x000000).
//  - READ/WRITE in NO_BURST: time_acc still advances by ts5; no event; err_orphan<=1.
//  - TIMESTAMP (any state): time_acc<=time_acc+payload (zero-extended); no event; state unchanged.
//  - Time arithmetic unsigned, wraps mod 2^TIME_W; ts5 and payload zero-extended.
//  - in_type/in_payload ignored when not accepted; no state change without a handshake.
//  - err_orphan clears only on reset.
//  - Reset mid-burst: pending event discarded, ev_valid=0 next cycle, state NO_BURST.
// CONFIGURATION
//  TRACE_DEC_STATS_EN defined:
//   - Adds outputs stat_addr, stat_read, stat_write, stat_ts (each 32 bit).
//   - Each counts accepted packets of its type, saturating at 0xFFFFFFFF; orphan data packets are counted.
//   - All counters reset to 0.
//  TRACE_DEC_STATS_EN undefined: ports and counters absent; decode behaviour identical.
// TESTING
//  1. ADDR 0x001000; WRITE ts5=3,ublb=00,d=0xBEEF; WRITE ts5=0,d=0x1234 ->
//     ADDR@0 a=0x001000; WRITE@3 a=0x001000 d=0xBEEF; WRITE@3 a=0x001001 d=0x1234.
//  2. ADDR 0; TIMESTAMP 0x400000; READ ts5=31 d=0xA5A5 -> ADDR@0; READ@0x40001F a=0 d=0xA5A5; only 2 events total.
//  3. After reset, READ ts5=5 -> no event, err_orphan=1; then ADDR 0x10 -> ADDR event @5 a=0x10.
//  4. ev_ready low 5 clks with 3 pkts queued at input -> in_ready low while ev_valid; ev_* stable; all 3 events delivered in order.
//  5. ADDR 0x7FFFFF; READ ×2 -> READ a=0x7FFFFF then READ a=0x000000.
//  6. Reset asserted mid-burst with ev_valid=1 -> next clk ev_valid=0; next READ is orphan; time restarts at 0.
//  (STATS_EN) Run scenario 1 -> stat_addr=1, stat_write=2, stat_read=0, stat_ts=0.

Source files
------------

// File: rtl/trace_packet_decoder.sv
// ---------------------------------------------------------------------------
// trace_packet_decoder
//
// Receive end of the RAM-tracer packet stream. Consumes {type, payload}
// packets and rebuilds absolute bus events: burst addresses, per-word
// read/write data and an absolute cycle time. Timestamp packets only advance
// the time accumulator and produce no event.
//
// Optional build: define TRACE_DEC_STATS_EN to add saturating per-type packet
// counters (stat_addr, stat_read, stat_write, stat_ts).
//
// Ports
//   mclk        in   system clock, all logic on posedge
//   reset       in   synchronous active-high reset
//   in_valid    in   input packet valid
//   in_ready    out  input packet accepted when in_valid && in_ready
//   in_type     in   00=ADDR 01=READ 10=WRITE 11=TIMESTAMP
//   in_payload  in   ADDR: address; READ/WRITE: {ts5, ublb, data};
//                    TIMESTAMP: cycle delta
//   ev_valid    out  decoded event valid
//   ev_ready    in   event consumed when ev_valid && ev_ready
//   ev_type     out  00=ADDR 01=READ 10=WRITE
//   ev_addr     out  word address of the event
//   ev_data     out  data word (0 for ADDR)
//   ev_ublb     out  byte-lane bits as received (0 for ADDR)
//   ev_time     out  absolute cycle time of the event
//   stat_*      out  (TRACE_DEC_STATS_EN only) accepted packets per type
//   err_orphan  out  sticky: data packet seen with no burst open
// ---------------------------------------------------------------------------
module trace_packet_decoder #(
    parameter int TIME_W = 32,
    parameter int ADDR_W = 23
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic [22:0]       in_payload,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [1:0]        ev_type,
    output logic [ADDR_W-1:0] ev_addr,
    output logic [15:0]       ev_data,
    output logic [1:0]        ev_ublb,
    output logic [TIME_W-1:0] ev_time,
`ifdef TRACE_DEC_STATS_EN
    output logic [31:0]       stat_addr,
    output logic [31:0]       stat_read,
    output logic [31:0]       stat_write,
    output logic [31:0]       stat_ts,
`endif
    output logic              err_orphan
);

    localparam logic [1:0] PKT_ADDR  = 2'b00;
    localparam logic [1:0] PKT_READ  = 2'b01;
    localparam logic [1:0] PKT_WRITE = 2'b10;
    localparam logic [1:0] PKT_TS    = 2'b11;

    localparam logic [0:0] NO_BURST  = 1'b0;
    localparam logic [0:0] IN_BURST  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [TIME_W-1:0] time_acc;

    logic              accept;
    logic              is_addr;
    logic              is_data;
    logic              emit;
    logic [TIME_W-1:0] time_adv;
    logic [TIME_W-1:0] time_next;

    // Single output register: a new packet may enter whenever the slot is
    // empty or is being drained this cycle.
    assign in_ready = !ev_valid || ev_ready;
    assign accept   = in_valid && in_ready;
    assign is_addr  = (in_type == PKT_ADDR);
    assign is_data  = (in_type == PKT_READ) || (in_type == PKT_WRITE);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        time_adv = '0;
        emit     = 1'b0;
        case (in_type)
            PKT_READ, PKT_WRITE: time_adv = TIME_W'(in_payload[22:18]);
            PKT_TS:              time_adv = TIME_W'(in_payload);
            default:             time_adv = '0;
        endcase
        // ADDR adds nothing, so time_next doubles as the ADDR event time.
        time_next = time_acc + time_adv;
        emit      = is_addr || (is_data && state == IN_BURST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state      <= NO_BURST;
            cur_addr   <= '0;
            time_acc   <= '0;
            ev_valid   <= 1'b0;
            ev_type    <= '0;
            ev_addr    <= '0;
            ev_data    <= '0;
            ev_ublb    <= '0;
            ev_time    <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (accept) begin
                time_acc <= time_next;
                if (is_addr) begin
                    cur_addr <= ADDR_W'(in_payload);
                    state    <= IN_BURST;
                end else if (is_data) begin
                    if (state == IN_BURST) begin
                        cur_addr <= cur_addr + ADDR_W'(1);
                    end else begin
                        err_orphan <= 1'b1;
                    end
                end
            end

            if (accept && emit) begin
                ev_valid <= 1'b1;
                ev_type  <= in_type;
                ev_addr  <= is_addr ? ADDR_W'(in_payload) : cur_addr;
                ev_data  <= is_addr ? 16'h0000 : in_payload[15:0];
                ev_ublb  <= is_addr ? 2'b00 : in_payload[17:16];
                ev_time  <= time_next;
            end else if (ev_ready) begin
                ev_valid <= 1'b0;
            end
        end
    end

`ifdef TRACE_DEC_STATS_EN
    // Saturating counters of accepted packets; orphan data packets count too.
    always_ff @(posedge mclk) begin
        if (reset) begin
            stat_addr  <= '0;
            stat_read  <= '0;
            stat_write <= '0;
            stat_ts    <= '0;
        end else if (accept) begin
            case (in_type)
                PKT_ADDR:  if (stat_addr  != '1) stat_addr  <= stat_addr  + 32'd1;
                PKT_READ:  if (stat_read  != '1) stat_read  <= stat_read  + 32'd1;
                PKT_WRITE: if (stat_write != '1) stat_write <= stat_write + 32'd1;
                default:   if (stat_ts    != '1) stat_ts    <= stat_ts    + 32'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_trace_packet_decoder.sv
// ---------------------------------------------------------------------------
// tb_trace_packet_decoder
//
// Self-checking bench for trace_packet_decoder. A packet-level reference
// model predicts each event (queue of expected events), the time accumulator
// and the orphan flag; directed scenarios add fixed expected values for the
// documented corner cases, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_trace_packet_decoder;

    typedef struct {
        logic [1:0]  t;
        logic [22:0] a;
        logic [15:0] d;
        logic [1:0]  u;
        logic [31:0] tm;
    } ev_t;

    logic        mclk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_type;
    logic [22:0] in_payload;
    logic        ev_valid;
    logic        ev_ready;
    logic [1:0]  ev_type;
    logic [22:0] ev_addr;
    logic [15:0] ev_data;
    logic [1:0]  ev_ublb;
    logic [31:0] ev_time;
    logic        err_orphan;
`ifdef TRACE_DEC_STATS_EN
    logic [31:0] stat_addr, stat_read, stat_write, stat_ts;
`endif

    trace_packet_decoder dut (
        .mclk       (mclk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_payload (in_payload),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_type    (ev_type),
        .ev_addr    (ev_addr),
        .ev_data    (ev_data),
        .ev_ublb    (ev_ublb),
        .ev_time    (ev_time),
`ifdef TRACE_DEC_STATS_EN
        .stat_addr  (stat_addr),
        .stat_read  (stat_read),
        .stat_write (stat_write),
        .stat_ts    (stat_ts),
`endif
        .err_orphan (err_orphan)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    ev_t         exp_q[$];
    ev_t         got[$];
    logic [31:0] m_time;
    logic [22:0] m_addr;
    bit          m_open;
    bit          m_orphan;
    int          m_cnt[4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one accepted packet to the model.
    task automatic model_apply(input logic [1:0] t, input logic [22:0] p);
        ev_t e;
        m_cnt[t]++;
        case (t)
            2'd0: begin
                m_addr = p;
                m_open = 1'b1;
                e = '{t: 2'd0, a: p, d: 16'h0, u: 2'b00, tm: m_time};
                exp_q.push_back(e);
            end
            2'd1, 2'd2: begin
                m_time = m_time + {27'd0, p[22:18]};
                if (m_open) begin
                    e = '{t: t, a: m_addr, d: p[15:0], u: p[17:16], tm: m_time};
                    exp_q.push_back(e);
                    m_addr = (m_addr + 23'd1) & 23'h7FFFFF;
                end else begin
                    m_orphan = 1'b1;
                end
            end
            default: m_time = m_time + {9'd0, p};
        endcase
    endtask

    // One clock of stimulus; all observation happens near the falling edge.
    task automatic cycle(input bit v, input logic [1:0] t, input logic [22:0] p,
                         input bit r, output bit acc);
        ev_t e;
        @(negedge mclk);
        in_valid   = v;
        in_type    = t;
        in_payload = p;
        ev_ready   = r;
        #1;
        check("ev_valid", ev_valid, exp_q.size() != 0);
        check("in_ready", in_ready, (exp_q.size() == 0) || r);
        check("err_orphan", err_orphan, m_orphan);
        if (ev_valid && exp_q.size() != 0) begin
            check("ev_type", ev_type, exp_q[0].t);
            check("ev_addr", ev_addr, exp_q[0].a);
            check("ev_data", ev_data, exp_q[0].d);
            check("ev_ublb", ev_ublb, exp_q[0].u);
            check("ev_time", ev_time, exp_q[0].tm);
            if (r) begin
                e = '{t: ev_type, a: ev_addr, d: ev_data, u: ev_ublb, tm: ev_time};
                got.push_back(e);
                void'(exp_q.pop_front());
            end
        end
        acc = v && in_ready;
        if (acc) model_apply(t, p);
        @(posedge mclk);
    endtask

    task automatic push_pkt(input logic [1:0] t, input logic [22:0] p);
        bit acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, t, p, 1'b1, acc);
        if (!acc) check("push_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        bit acc;
        repeat (2) cycle(1'b0, 2'd0, 23'd0, 1'b1, acc);
    endtask

    task automatic do_reset();
        @(negedge mclk);
        reset    = 1'b1;
        in_valid = 1'b0;
        ev_ready = 1'($urandom);
        @(posedge mclk);
        @(negedge mclk);
        #1;
        check("rst_ev_valid", ev_valid, 1'b0);
        check("rst_err_orphan", err_orphan, 1'b0);
        check("rst_ev_time", ev_time, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        got.delete();
        m_time   = '0;
        m_addr   = '0;
        m_open   = 1'b0;
        m_orphan = 1'b0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
    endtask

    function automatic logic [22:0] rw(input logic [4:0] ts, input logic [1:0] u,
                                       input logic [15:0] d);
        return {ts, u, d};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_type    = '0;
        in_payload = '0;
        ev_ready   = 1'b0;
        do_reset();

        // Scenario 1: burst of two writes
        push_pkt(2'd0, 23'h001000);
        push_pkt(2'd2, rw(5'd3, 2'b00, 16'hBEEF));
        push_pkt(2'd2, rw(5'd0, 2'b00, 16'h1234));
        drain();
        check("s1_count", got.size(), 3);
        if (got.size() == 3) begin
            check("s1_e0", {got[0].t, got[0].a, got[0].tm}, {2'd0, 23'h001000, 32'd0});
            check("s1_e1", {got[1].t, got[1].a, got[1].d, got[1].tm}, {2'd2, 23'h001000, 16'hBEEF, 32'd3});
            check("s1_e2", {got[2].t, got[2].a, got[2].d, got[2].tm}, {2'd2, 23'h001001, 16'h1234, 32'd3});
        end
`ifdef TRACE_DEC_STATS_EN
        check("stat_addr", stat_addr, 32'd1);
        check("stat_write", stat_write, 32'd2);
        check("stat_read", stat_read, 32'd0);
        check("stat_ts", stat_ts, 32'd0);
`endif

        // Scenario 2: timestamp absorbed, large delta
        do_reset();
        push_pkt(2'd0, 23'h0);
        push_pkt(2'd3, 23'h400000);
        push_pkt(2'd1, rw(5'd31, 2'b00, 16'hA5A5));
        drain();
        check("s2_count", got.size(), 2);
        if (got.size() == 2)
            check("s2_read", {got[1].t, got[1].a, got[1].d, got[1].tm}, {2'd1, 23'h0, 16'hA5A5, 32'h0040001F});

        // Scenario 3: orphan read then address
        do_reset();
        push_pkt(2'd1, rw(5'd5, 2'b01, 16'h7777));
        drain();
        check("s3_orphan", err_orphan, 1'b1);
        check("s3_no_event", got.size(), 0);
        push_pkt(2'd0, 23'h000010);
        drain();
        check("s3_count", got.size(), 1);
        if (got.size() == 1) check("s3_addr", {got[0].a, got[0].tm}, {23'h10, 32'd5});
        check("s3_sticky", err_orphan, 1'b1);

        // Scenario 4: consumer stalls while packets wait at the input
        do_reset();
        cycle(1'b1, 2'd0, 23'h000200, 1'b0, acc);
        check("s4_first_acc", acc, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2'd1, rw(5'd1, 2'b10, 16'h1000), 1'b0, acc);
            check("s4_stall", acc, 1'b0);
        end
        push_pkt(2'd1, rw(5'd1, 2'b10, 16'h1000));
        push_pkt(2'd2, rw(5'd2, 2'b11, 16'h2000));
        drain();
        check("s4_count", got.size(), 3);
        if (got.size() == 3) begin
            check("s4_e0", {got[0].t, got[0].a}, {2'd0, 23'h200});
            check("s4_e1", {got[1].t, got[1].a, got[1].tm}, {2'd1, 23'h200, 32'd1});
            check("s4_e2", {got[2].t, got[2].a, got[2].u, got[2].tm}, {2'd2, 23'h201, 2'b11, 32'd3});
        end

        // Scenario 5: address wrap
        do_reset();
        push_pkt(2'd0, 23'h7FFFFF);
        push_pkt(2'd1, rw(5'd0, 2'b00, 16'h0001));
        push_pkt(2'd1, rw(5'd0, 2'b00, 16'h0002));
        drain();
        check("s5_count", got.size(), 3);
        if (got.size() == 3) begin
            check("s5_top", got[1].a, 23'h7FFFFF);
            check("s5_wrap", got[2].a, 23'h000000);
        end

        // Scenario 6: reset with a pending event
        do_reset();
        push_pkt(2'd1, rw(5'd9, 2'b00, 16'h0));
        cycle(1'b1, 2'd0, 23'h000050, 1'b0, acc);
        cycle(1'b0, 2'd0, 23'h0, 1'b0, acc);
        do_reset();
        push_pkt(2'd1, rw(5'd2, 2'b00, 16'h0003));
        drain();
        check("s6_orphan", err_orphan, 1'b1);
        push_pkt(2'd0, 23'h0);
        drain();
        check("s6_count", got.size(), 1);
        if (got.size() == 1) check("s6_time", got[0].tm, 32'd2);

        // Randomized run
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int sel;
            logic [1:0] t;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                sel = $urandom_range(0, 7);
                t = (sel == 0) ? 2'd0 : (sel <= 3) ? 2'd1 : (sel <= 6) ? 2'd2 : 2'd3;
                cycle($urandom_range(0, 9) < 7, t, 23'($urandom),
                      $urandom_range(0, 9) < 7, acc);
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
